issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Parametrised successor to the dual-slot issue stage.
- Sits between fetch and the two slot decoders (branch/int slot "bra", load-store/int slot "ls").
- Buffers fetched instruction pairs in a circular FIFO. A structural conflict (two branches or two memory ops in the same pair) splits the pair over two cycles instead of stalling fetch.
- Each cycle it dispatches 0, 1 or 2 oldest entries, in order, into registered slot outputs.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4
- XLEN, 32, instruction and PC width
- NOP_INSTR, 32'h00000013, filler for an unused slot in a valid issue cycle

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- fetch_valid_i  in  1  instr_i_1/instr_i_2 pair valid (always both)
- fetch_ready_o  out  1  queue accepts a pair this cycle
- instr_i_1  in  XLEN  older fetched instruction
- pc_1  in  XLEN  PC of instr_i_1
- instr_i_2  in  XLEN  younger fetched instruction
- pc_2  in  XLEN  PC of instr_i_2
- flush  in  1  redirect; discard all buffered and issued state
- stall_en  in  1  downstream hold; outputs frozen, no dequeue
- instr_bra_int_o  out  XLEN  bra slot instruction
- pc_bra_int_o  out  XLEN  bra slot PC
- instr_ls_int_o  out  XLEN  ls slot instruction
- pc_ls_int_o  out  XLEN  ls slot PC
- prio_o  out  1  0: bra slot holds the older instruction; 1: ls slot holds it
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - head, tail, count = 0
  - all instr/pc outputs = 0, prio_o = 0
- Class by opcode [6:0]:
  - BR: 1100011, 1101111, 1100111
  - LS: 0000011, 0100011
  - INT: everything else
- Enqueue:
  - Fires when fetch_valid_i && fetch_ready_o && !flush.
  - instr_i_1 is written at tail, instr_i_2 at tail+1; tail += 2 modulo DEPTH.
- fetch_ready_o = (DEPTH - count) >= 2. It uses the registered count and does not account for the same-cycle dequeue.
- Dispatch (when !stall_en && !flush). H0 is the head entry, H1 is head+1 when count >= 2.
  - count==0: both instrs = NOP_INSTR, PCs hold, prio 0, pop 0.
  - H0 BR: H0 to bra, prio 0. If H1 exists and is not BR, H1 goes to ls and pop 2. Otherwise ls = NOP_INSTR, pop 1.
  - H0 LS: H0 to ls, prio 1. If H1 exists and is not LS, H1 goes to bra and pop 2. Otherwise bra = NOP_INSTR, pop 1.
  - H0 INT, H1 BR: H1 to bra, H0 to ls, prio 1, pop 2.
  - H0 INT, H1 LS or INT: H0 to bra, H1 to ls, prio 0, pop 2.
  - H0 INT, no H1: H0 to bra, ls = NOP_INSTR, prio 0, pop 1.
  - A NOP slot's PC is the issued instruction's PC.
- Latency: a pair written at edge N can appear on the outputs at edge N+1 at the earliest.
- count update: count_next = count + 2*enq - pop. Same-cycle enqueue and dequeue is legal; pointers wrap modulo DEPTH.
- stall_en=1: outputs and head hold; enqueue still permitted while ready.
- flush=1 (priority over stall and enqueue):
  - head = tail = count = 0
  - instr outputs = 0, PCs hold, prio 0
  - the incoming pair is dropped
- Never overflow: an enqueue when not ready is ignored. Never underflow: pop <= count.

Optional Feature:
- Macro: ISSUE_QUEUE_PERF_EN.
- When defined:
  - Adds outputs dual_cnt_o[31:0] and single_cnt_o[31:0].
  - They count dispatch cycles with pop==2 and pop==1 respectively.
  - They are cleared by reset only (not by flush) and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package issue_pkg holds:
  - opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE
  - enum instr_class_e {CLS_INT, CLS_BR, CLS_LS}
  - struct issue_entry_t {instr, pc}
  - NOP constant
- One sub-module, issue_pair_select: purely combinational. Takes H0, H1, h1_valid and produces slot contents, prio and pop count. issue_queue owns the FIFO, pointers and output registers.

Test Plan:
- Reset mid-stream with count=5 → count_o=0, all outputs 0 and prio_o=0 asynchronously; fetch_ready_o=1 next cycle.
- Push pair (beq @0x100, addi @0x104) → next edge bra=beq/pc 0x100, ls=addi/pc 0x104, prio 0, count returns to 0.
- Push (lw @0x200, sw @0x204) → cycle 1: ls=lw, bra=0x00000013, prio 1. Cycle 2: ls=sw, prio 1. fetch is never stalled.
- Push (addi @0x300, jal @0x304) → bra=jal, ls=addi, prio 1.
- With stall_en=1, push 4 pairs with DEPTH=8 → count_o=8, fetch_ready_o=0, fifth pair ignored, outputs frozen. Release stall → entries drain in order, pointers wrap correctly.
- Flush asserted while fetch_valid_i=1 and count=6 → count_o=0, instrs 0; the dropped pair never issues.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the dual-slot issue queue: opcode classes,
// FIFO entry layout and the filler instruction used for empty slots.
package issue_pkg;

    localparam int ISSUE_XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [ISSUE_XLEN-1:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        CLS_INT,
        CLS_BR,
        CLS_LS
    } instr_class_e;

    typedef struct packed {
        logic [ISSUE_XLEN-1:0] instr;
        logic [ISSUE_XLEN-1:0] pc;
    } issue_entry_t;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OPC_BRANCH, OPC_JAL, OPC_JALR: cls = CLS_BR;
            OPC_LOAD, OPC_STORE:           cls = CLS_LS;
            default:                       cls = CLS_INT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side and issue-side signal bundle of the issue queue; the queue uses
// the slave modport, fetch/decode (or a bench) the master modport.
interface issue_queue_if
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = ISSUE_XLEN
);
    logic                    fetch_valid_i;
    logic                    fetch_ready_o;
    logic [XLEN-1:0]         instr_i_1;
    logic [XLEN-1:0]         pc_1;
    logic [XLEN-1:0]         instr_i_2;
    logic [XLEN-1:0]         pc_2;
    logic [XLEN-1:0]         instr_bra_int_o;
    logic [XLEN-1:0]         pc_bra_int_o;
    logic [XLEN-1:0]         instr_ls_int_o;
    logic [XLEN-1:0]         pc_ls_int_o;
    logic                    prio_o;
    logic [$clog2(DEPTH):0]  count_o;

    modport master (
        output fetch_valid_i, instr_i_1, pc_1, instr_i_2, pc_2,
        input  fetch_ready_o, instr_bra_int_o, pc_bra_int_o,
               instr_ls_int_o, pc_ls_int_o, prio_o, count_o
    );

    modport slave (
        input  fetch_valid_i, instr_i_1, pc_1, instr_i_2, pc_2,
        output fetch_ready_o, instr_bra_int_o, pc_bra_int_o,
               instr_ls_int_o, pc_ls_int_o, prio_o, count_o
    );

endinterface

// File: rtl/issue_queue_pair_select.sv
// Combinational slot steering for the two oldest queue entries: decides which
// entry goes to the bra/ls slots, which slot is older and how many to pop.
module issue_pair_select
    import issue_pkg::*;
#(
    parameter logic [ISSUE_XLEN-1:0] NOP_INSTR = NOP
) (
    input  issue_entry_t h0_i,
    input  issue_entry_t h1_i,
    input  logic         h1_valid_i,
    output issue_entry_t bra_o,
    output issue_entry_t ls_o,
    output logic         prio_o,
    output logic [1:0]   pop_o
);

    instr_class_e cls0;
    instr_class_e cls1;

    assign cls0 = classify(h0_i.instr[6:0]);
    assign cls1 = classify(h1_i.instr[6:0]);

    // A slot left empty carries the filler instruction with the PC of the
    // instruction that did issue, so downstream always sees a sane PC.
    always_comb begin
        bra_o  = h0_i;
        ls_o   = '{instr: NOP_INSTR, pc: h0_i.pc};
        prio_o = 1'b0;
        pop_o  = 2'd1;
        case (cls0)
            CLS_BR: begin
                if (h1_valid_i && cls1 != CLS_BR) begin
                    ls_o  = h1_i;
                    pop_o = 2'd2;
                end
            end
            CLS_LS: begin
                ls_o   = h0_i;
                bra_o  = '{instr: NOP_INSTR, pc: h0_i.pc};
                prio_o = 1'b1;
                if (h1_valid_i && cls1 != CLS_LS) begin
                    bra_o = h1_i;
                    pop_o = 2'd2;
                end
            end
            default: begin
                if (h1_valid_i) begin
                    pop_o = 2'd2;
                    if (cls1 == CLS_BR) begin
                        bra_o  = h1_i;
                        ls_o   = h0_i;
                        prio_o = 1'b1;
                    end else begin
                        ls_o = h1_i;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/issue_queue.sv
// Circular FIFO of fetched instruction pairs feeding the registered bra/ls
// issue slots. Define ISSUE_QUEUE_PERF_EN to add dual/single dispatch counters.
module issue_queue
    import issue_pkg::*;
#(
    parameter int                DEPTH     = 8,
    parameter int                XLEN      = ISSUE_XLEN,
    parameter logic [XLEN-1:0]   NOP_INSTR = NOP
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush,
    input  logic          stall_en,
    issue_queue_if.slave  bus
`ifdef ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]   dual_cnt_o,
    output logic [31:0]   single_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    issue_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, headP1, tailP1;
    logic [CW-1:0]   count_q, count_d;
    issue_entry_t    bra_q, ls_q, selBra, selLs;
    logic            prio_q, selPrio, fetchReady, enqFire, dispatch;
    logic [1:0]      selPop, popCnt;

    assign fetchReady = count_q <= CW'(DEPTH - 2);
    assign enqFire    = bus.fetch_valid_i && fetchReady && !flush;
    assign dispatch   = !stall_en && !flush;
    assign headP1     = head_q + PW'(1);
    assign tailP1     = tail_q + PW'(1);

    issue_pair_select #(.NOP_INSTR(NOP_INSTR)) u_select (
        .h0_i       (mem_q[head_q]),
        .h1_i       (mem_q[headP1]),
        .h1_valid_i (count_q >= CW'(2)),
        .bra_o      (selBra),
        .ls_o       (selLs),
        .prio_o     (selPrio),
        .pop_o      (selPop)
    );

    assign popCnt = (dispatch && count_q != '0) ? selPop : 2'd0;

    always_comb begin
        head_d  = head_q + PW'(popCnt);
        tail_d  = enqFire ? tail_q + PW'(2) : tail_q;
        count_d = count_q + (enqFire ? CW'(2) : CW'(0)) - CW'(popCnt);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (enqFire) begin
            mem_q[tail_q] <= '{instr: bus.instr_i_1, pc: bus.pc_1};
            mem_q[tailP1] <= '{instr: bus.instr_i_2, pc: bus.pc_2};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            bra_q   <= '0;
            ls_q    <= '0;
            prio_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                bra_q.instr <= '0;
                ls_q.instr  <= '0;
                prio_q      <= 1'b0;
            end else if (!stall_en) begin
                if (count_q == '0) begin
                    bra_q.instr <= NOP_INSTR;
                    ls_q.instr  <= NOP_INSTR;
                    prio_q      <= 1'b0;
                end else begin
                    bra_q  <= selBra;
                    ls_q   <= selLs;
                    prio_q <= selPrio;
                end
            end
        end
    end

`ifdef ISSUE_QUEUE_PERF_EN
    // Counters survive flush on purpose so they reflect the whole run.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dual_cnt_o   <= '0;
            single_cnt_o <= '0;
        end else begin
            if (popCnt == 2'd2 && dual_cnt_o != 32'hFFFFFFFF) begin
                dual_cnt_o <= dual_cnt_o + 32'd1;
            end
            if (popCnt == 2'd1 && single_cnt_o != 32'hFFFFFFFF) begin
                single_cnt_o <= single_cnt_o + 32'd1;
            end
        end
    end
`endif

    assign bus.fetch_ready_o   = fetchReady;
    assign bus.instr_bra_int_o = bra_q.instr;
    assign bus.pc_bra_int_o    = bra_q.pc;
    assign bus.instr_ls_int_o  = ls_q.instr;
    assign bus.pc_ls_int_o     = ls_q.pc;
    assign bus.prio_o          = prio_q;
    assign bus.count_o         = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed, scoreboard-driven bench for issue_queue (DEPTH=8): expected issue
// slots are queued with the stimulus and popped as the DUT dispatches.
module tb_issue_queue;

    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] LW   = 32'h0000a103;
    localparam logic [31:0] SW   = 32'h0020a223;
    localparam logic [31:0] JAL  = 32'h0080006f;
    localparam logic [31:0] NOPI = 32'h00000013;

    typedef struct {
        logic [31:0] braI;
        logic [31:0] braPc;
        logic [31:0] lsI;
        logic [31:0] lsPc;
        logic        prio;
    } exp_t;

    logic clk;
    logic rstn;
    logic flush;
    logic stall_en;
    int   checks;
    int   errors;
    exp_t sbQ[$];

    issue_queue_if #(.DEPTH(8), .XLEN(32)) bus ();

`ifdef ISSUE_QUEUE_PERF_EN
    logic [31:0] dualCnt;
    logic [31:0] singleCnt;
`endif

    issue_queue #(.DEPTH(8)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .flush    (flush),
        .stall_en (stall_en),
        .bus      (bus)
`ifdef ISSUE_QUEUE_PERF_EN
        ,
        .dual_cnt_o   (dualCnt),
        .single_cnt_o (singleCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] i1, input logic [31:0] p1,
                                 input logic [31:0] i2, input logic [31:0] p2);
        bus.fetch_valid_i = v;
        bus.instr_i_1     = i1;
        bus.pc_1          = p1;
        bus.instr_i_2     = i2;
        bus.pc_2          = p2;
    endtask

    task automatic expectIssue(input logic [31:0] bi, input logic [31:0] bp,
                               input logic [31:0] li, input logic [31:0] lp, input logic pr);
        exp_t e;
        e.braI = bi; e.braPc = bp; e.lsI = li; e.lsPc = lp; e.prio = pr;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=issue expected=empty_scoreboard", tag);
        end else begin
            e = sbQ.pop_front();
            checkVal({tag, "_bra"},   bus.instr_bra_int_o, e.braI);
            checkVal({tag, "_brapc"}, bus.pc_bra_int_o,    e.braPc);
            checkVal({tag, "_ls"},    bus.instr_ls_int_o,  e.lsI);
            checkVal({tag, "_lspc"},  bus.pc_ls_int_o,     e.lsPc);
            checkVal({tag, "_prio"},  32'(bus.prio_o),     32'(e.prio));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        flush    = 1'b0;
        stall_en = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);

        // Reset state
        #2;
        checkVal("rst_count", 32'(bus.count_o), 32'd0);
        checkVal("rst_bra",   bus.instr_bra_int_o, 32'd0);
        checkVal("rst_ls",    bus.instr_ls_int_o,  32'd0);
        checkVal("rst_prio",  32'(bus.prio_o),     32'd0);
        checkVal("rst_ready", 32'(bus.fetch_ready_o), 32'd1);
        tick();
        rstn = 1'b1;

        // Branch + int pair issues together one edge after enqueue
        applyStimulus(1'b1, BEQ, 32'h100, ADDI, 32'h104);
        expectIssue(BEQ, 32'h100, ADDI, 32'h104, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkVal("enq_count", 32'(bus.count_o), 32'd2);
        tick();
        checkOutput("br_int");
        checkVal("br_int_count", 32'(bus.count_o), 32'd0);
        tick();
        checkVal("idle_bra",   bus.instr_bra_int_o, NOPI);
        checkVal("idle_ls",    bus.instr_ls_int_o,  NOPI);
        checkVal("idle_brapc", bus.pc_bra_int_o,    32'h100);
        checkVal("idle_lspc",  bus.pc_ls_int_o,     32'h104);

        // Two memory ops split over two cycles
        applyStimulus(1'b1, LW, 32'h200, SW, 32'h204);
        expectIssue(NOPI, 32'h200, LW, 32'h200, 1'b1);
        expectIssue(NOPI, 32'h204, SW, 32'h204, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        checkVal("ls_ready", 32'(bus.fetch_ready_o), 32'd1);
        tick();
        checkOutput("ls_split1");
        checkVal("ls_split1_count", 32'(bus.count_o), 32'd1);
        tick();
        checkOutput("ls_split2");
        checkVal("ls_split2_count", 32'(bus.count_o), 32'd0);

        // Int followed by jump: jump takes the bra slot, ls slot is older
        applyStimulus(1'b1, ADDI, 32'h300, JAL, 32'h304);
        expectIssue(JAL, 32'h304, ADDI, 32'h300, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        tick();
        checkOutput("int_jal");
        tick();

        // Fill to full under stall, overflow attempt, then drain across the wrap
        stall_en = 1'b1;
        expectIssue(ADDI, 32'h400, ADDI, 32'h404, 1'b0);
        expectIssue(ADDI, 32'h40c, LW,   32'h408, 1'b1);
        expectIssue(BEQ,  32'h410, NOPI, 32'h410, 1'b0);
        expectIssue(BEQ,  32'h414, SW,   32'h418, 1'b0);
        expectIssue(JAL,  32'h41c, NOPI, 32'h41c, 1'b0);
        applyStimulus(1'b1, ADDI, 32'h400, ADDI, 32'h404);
        tick();
        applyStimulus(1'b1, LW, 32'h408, ADDI, 32'h40c);
        tick();
        applyStimulus(1'b1, BEQ, 32'h410, BEQ, 32'h414);
        tick();
        applyStimulus(1'b1, SW, 32'h418, JAL, 32'h41c);
        tick();
        checkVal("full_count", 32'(bus.count_o), 32'd8);
        checkVal("full_ready", 32'(bus.fetch_ready_o), 32'd0);
        applyStimulus(1'b1, ADDI, 32'h500, ADDI, 32'h504);
        tick();
        checkVal("ovf_count",    32'(bus.count_o), 32'd8);
        checkVal("frozen_bra",   bus.instr_bra_int_o, NOPI);
        checkVal("frozen_brapc", bus.pc_bra_int_o,    32'h304);
        checkVal("frozen_lspc",  bus.pc_ls_int_o,     32'h300);
        applyStimulus(1'b0, '0, '0, '0, '0);
        stall_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("drain%0d", i));
        end
        checkVal("drain_count", 32'(bus.count_o), 32'd0);
        tick();
        checkVal("drop_ovf_bra", bus.instr_bra_int_o, NOPI);
        checkVal("drop_ovf_ls",  bus.instr_ls_int_o,  NOPI);

        // Flush with count=6 and a pair on the fetch port
        stall_en = 1'b1;
        applyStimulus(1'b1, ADDI, 32'h600, ADDI, 32'h604);
        tick();
        applyStimulus(1'b1, ADDI, 32'h608, ADDI, 32'h60c);
        tick();
        applyStimulus(1'b1, ADDI, 32'h610, ADDI, 32'h614);
        tick();
        checkVal("preflush_count", 32'(bus.count_o), 32'd6);
        flush = 1'b1;
        applyStimulus(1'b1, BEQ, 32'h700, ADDI, 32'h704);
        tick();
        checkVal("flush_count", 32'(bus.count_o), 32'd0);
        checkVal("flush_bra",   bus.instr_bra_int_o, 32'd0);
        checkVal("flush_ls",    bus.instr_ls_int_o,  32'd0);
        checkVal("flush_prio",  32'(bus.prio_o),     32'd0);
        checkVal("flush_brapc", bus.pc_bra_int_o,    32'h41c);
        flush    = 1'b0;
        stall_en = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);
        tick();
        checkVal("postflush_count", 32'(bus.count_o), 32'd0);
        checkVal("postflush_bra",   bus.instr_bra_int_o, NOPI);
        checkVal("postflush_brapc", bus.pc_bra_int_o,    32'h41c);

        // Build count=5 with memory-op pairs, then reset asynchronously
        applyStimulus(1'b1, LW, 32'h800, SW, 32'h804);
        for (int i = 0; i < 4; i++) tick();
        checkVal("pre_rst_count", 32'(bus.count_o), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        checkVal("arst_count", 32'(bus.count_o), 32'd0);
        checkVal("arst_bra",   bus.instr_bra_int_o, 32'd0);
        checkVal("arst_brapc", bus.pc_bra_int_o,    32'd0);
        checkVal("arst_ls",    bus.instr_ls_int_o,  32'd0);
        checkVal("arst_lspc",  bus.pc_ls_int_o,     32'd0);
        checkVal("arst_prio",  32'(bus.prio_o),     32'd0);
        applyStimulus(1'b0, '0, '0, '0, '0);
        rstn = 1'b1;
        tick();
        checkVal("arst_ready", 32'(bus.fetch_ready_o), 32'd1);
        checkVal("arst_count_after", 32'(bus.count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
